// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-port MIG arbiter: command codes and FSM states.
package mem_arbiter_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [2:0] {
      S_CALIB,
      S_IDLE,
      S_WR_DATA,
      S_WR_CMD,
      S_RD_CMD,
      S_DONE
   } state_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational picker: highest pressure among requesters, ties resolved to the first
// requester at or after rr_ptr in cyclic order.
module mem_arb_select #(
   parameter  int NUM_PORTS = 4,
   parameter  int LVL_W     = 9,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0]       req,
   input  logic [NUM_PORTS*LVL_W-1:0] req_lvl,
   input  logic [IDX_W-1:0]           rr_ptr,
   output logic                       valid,
   output logic [IDX_W-1:0]           winner
);

   logic [LVL_W-1:0] lvl_a [NUM_PORTS];
   logic [LVL_W-1:0] best;
   logic [IDX_W:0]   pos;
   logic [IDX_W-1:0] idx;
   logic             found;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign lvl_a[p] = req_lvl[p*LVL_W +: LVL_W];
   end

   // Walk ports in cyclic order from rr_ptr; strict '>' keeps the earliest of equal levels.
   always_comb begin
      found  = 1'b0;
      best   = '0;
      winner = rr_ptr;
      pos    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(NUM_PORTS)) pos = pos - (IDX_W+1)'(NUM_PORTS);
         idx = pos[IDX_W-1:0];
         if (req[idx] && (!found || lvl_a[idx] > best)) begin
            found  = 1'b1;
            best   = lvl_a[idx];
            winner = idx;
         end
      end
      valid = found;
   end

endmodule

// File: rtl/mem_arbiter_mp.sv
// N-port burst arbiter in front of the MIG user interface: one read or write burst
// at a time, granted by pressure with round-robin tie-break.
module mem_arbiter_mp
   import mem_arbiter_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   parameter  int ADDR_W    = 29,
   parameter  int MASK_W    = 16,
   parameter  int LEN_W     = 4,
   parameter  int LVL_W     = 9,
   parameter  int ADDR_INC  = 8,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        calib_done,
   input  logic                        app_rdy,
   output logic                        app_en,
   output logic [2:0]                  app_cmd,
   output logic [ADDR_W-1:0]           app_addr,
   input  logic                        app_wdf_rdy,
   output logic                        app_wdf_wren,
   output logic                        app_wdf_end,
   output logic [MASK_W-1:0]           app_wdf_mask,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [NUM_PORTS-1:0]        req_rd,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
   input  logic [NUM_PORTS*LVL_W-1:0]  req_lvl,
   output logic [NUM_PORTS-1:0]        wdata_rd_en,
   output logic [NUM_PORTS-1:0]        ack,
   output logic                        busy,
   output logic [IDX_W-1:0]            grant_id
);

   localparam logic [LEN_W:0]     CNT_ONE  = (LEN_W+1)'(1);
   localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

   state_t             state, nxt;
   logic [IDX_W-1:0]   rr_ptr, gnt;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W:0]     cnt;
   logic               pop_q, wren_q;
   logic               sel_valid, grant, cmd_acc, last;
   logic [IDX_W-1:0]   sel_winner;
   logic [ADDR_W-1:0]  addr_a [NUM_PORTS];
   logic [LEN_W-1:0]   len_a  [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign addr_a[p] = req_addr[p*ADDR_W +: ADDR_W];
      assign len_a[p]  = req_len[p*LEN_W +: LEN_W];
   end

   mem_arb_select #(
      .NUM_PORTS (NUM_PORTS),
      .LVL_W     (LVL_W)
   ) u_select (
      .req     (req),
      .req_lvl (req_lvl),
      .rr_ptr  (rr_ptr),
      .valid   (sel_valid),
      .winner  (sel_winner)
   );

   assign last = (cnt == CNT_ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_CALIB;
      else       state <= nxt;
   end

   always_comb begin
      nxt     = state;
      grant   = 1'b0;
      cmd_acc = 1'b0;
      case (state)
         S_CALIB: if (calib_done) nxt = S_IDLE;
         S_IDLE: begin
            if (!calib_done) nxt = S_CALIB;
            else if (sel_valid) begin
               grant = 1'b1;
               nxt   = req_rd[sel_winner] ? S_RD_CMD : S_WR_DATA;
            end
         end
         S_WR_DATA: if (wren_q && app_wdf_rdy) nxt = S_WR_CMD;
         S_WR_CMD: if (app_rdy) begin
            cmd_acc = 1'b1;
            nxt     = last ? S_DONE : S_WR_DATA;
         end
         S_RD_CMD: if (app_rdy) begin
            cmd_acc = 1'b1;
            nxt     = last ? S_DONE : S_RD_CMD;
         end
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_CALIB;
      endcase
   end

   // Burst context: latched on grant, advanced on every accepted command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
         gnt    <= '0;
         addr_q <= '0;
         cnt    <= '0;
         pop_q  <= 1'b0;
         wren_q <= 1'b0;
      end else begin
         pop_q  <= 1'b0;
         wren_q <= (state == S_WR_DATA) && !(wren_q && app_wdf_rdy);
         if (grant) begin
            gnt    <= sel_winner;
            addr_q <= addr_a[sel_winner];
            cnt    <= {1'b0, len_a[sel_winner]} + CNT_ONE;
            rr_ptr <= (sel_winner == IDX_W'(NUM_PORTS-1)) ? '0 : sel_winner + 1'b1;
            pop_q  <= !req_rd[sel_winner];
         end
         if (cmd_acc) begin
            addr_q <= addr_q + ADDR_W'(ADDR_INC);
            cnt    <= cnt - CNT_ONE;
            pop_q  <= (state == S_WR_CMD) && !last;
         end
      end
   end

   assign app_en       = (state == S_WR_CMD) || (state == S_RD_CMD);
   assign app_cmd      = (state == S_RD_CMD) ? CMD_READ : CMD_WRITE;
   assign app_addr     = addr_q;
   assign app_wdf_wren = wren_q;
   assign app_wdf_end  = wren_q;
   assign app_wdf_mask = '0;
   assign wdata_rd_en  = pop_q ? (ONE_HOT0 << gnt) : '0;
   assign ack          = (state == S_DONE) ? (ONE_HOT0 << gnt) : '0;
   // S_CALIB after reset counts as busy, but outputs read 0 while reset is held.
   assign busy         = (state != S_IDLE) && !reset;
   assign grant_id     = gnt;

endmodule
